// File: rtl/relu_clip_if.sv
// relu_clip_if: bundles the input-beat and output-beat handshakes of the
// activation stage.
//   i_data/i_valid/i_ready/i_mode/i_clip : upstream beat (accumulator side)
//   o_data/o_valid/o_ready/o_mode        : downstream beat (pooling buffer side)
// master = the environment driving beats in and accepting beats out,
// slave  = the activation stage itself.
interface relu_clip_if #(
    parameter int COL   = 3,
    parameter int W_IN  = 32,
    parameter int W_OUT = 8
);
    logic [COL*W_IN-1:0]  i_data;
    logic                 i_valid;
    logic                 i_ready;
    logic [1:0]           i_mode;
    logic [W_OUT-1:0]     i_clip;
    logic [COL*W_OUT-1:0] o_data;
    logic                 o_valid;
    logic                 o_ready;
    logic [1:0]           o_mode;

    modport master (
        output i_data, i_valid, i_mode, i_clip, o_ready,
        input  i_ready, o_data, o_valid, o_mode
    );

    modport slave (
        input  i_data, i_valid, i_mode, i_clip, o_ready,
        output i_ready, o_data, o_valid, o_mode
    );
endinterface

// File: rtl/relu_clip_array.sv
// relu_clip_array: COL-lane activation stage between the systolic-array
// column accumulators and the output/pooling buffer.
// Per lane it applies ReLU-with-saturation (mode 0/3), ReLU with a
// programmable clip threshold (mode 1) or leaky ReLU (mode 2), through a
// 2-stage valid/ready pipeline with back-pressure, and counts (saturating)
// accepted beats in which any lane clipped.
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus         : relu_clip_if.slave (input beat, output beat, mode/clip)
//   i_cnt_clr   : synchronous clear of o_clip_cnt (wins over increment)
//   o_clip_cnt  : saturating count of clipping input beats
module relu_clip_array #(
    parameter int COL     = 3,
    parameter int W_IN    = 32,
    parameter int W_OUT   = 8,
    parameter int LEAK_SH = 3,
    parameter int W_CNT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    relu_clip_if.slave       bus,
    input  logic             i_cnt_clr,
    output logic [W_CNT-1:0] o_clip_cnt
);

    localparam logic signed [W_IN-1:0] ZERO_S = '0;
    localparam logic signed [W_IN-1:0] U_S    = W_IN'((2 ** W_OUT) - 1);
    localparam logic signed [W_IN-1:0] SMAX_S = W_IN'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [W_IN-1:0] SMIN_S = W_IN'(-(2 ** (W_OUT - 1)));
    localparam logic [W_OUT-1:0]       U_O    = U_S[W_OUT-1:0];
    localparam logic [W_OUT-1:0]       SMAX_O = SMAX_S[W_OUT-1:0];
    localparam logic [W_OUT-1:0]       SMIN_O = SMIN_S[W_OUT-1:0];
    localparam logic [W_CNT-1:0]       CNT_MAX = '1;

    // Returns {clip_flag, lane_result}. All compares use the full-width
    // signed input so large accumulator values never alias into range.
    function automatic logic [W_OUT:0] lane_act(
        input logic signed [W_IN-1:0] x,
        input logic [1:0]             mode,
        input logic [W_OUT-1:0]       clip
    );
        logic signed [W_IN-1:0] clip_s;
        logic signed [W_IN-1:0] y;
        logic [W_OUT:0]         r;
        clip_s = $signed({{(W_IN-W_OUT){1'b0}}, clip});
        y      = x >>> LEAK_SH;   // floor division for negative leaky inputs
        r      = '0;
        case (mode)
            2'd1: begin
                if (x <= ZERO_S)      r = '0;
                else if (x > clip_s)  r = {1'b1, clip};
                else                  r = {1'b0, x[W_OUT-1:0]};
            end
            2'd2: begin
                if (x >= ZERO_S) begin
                    if (x > SMAX_S)   r = {1'b1, SMAX_O};
                    else              r = {1'b0, x[W_OUT-1:0]};
                end else begin
                    if (y < SMIN_S)   r = {1'b1, SMIN_O};
                    else              r = {1'b0, y[W_OUT-1:0]};
                end
            end
            default: begin
                if (x <= ZERO_S)      r = '0;
                else if (x > U_S)     r = {1'b1, U_O};
                else                  r = {1'b0, x[W_OUT-1:0]};
            end
        endcase
        return r;
    endfunction

    logic [COL*W_OUT-1:0] res_p0;
    logic                 clip_any_p0;
    logic [W_OUT:0]       lane_r;

    logic                 vld_p1_q, vld_p1_d;
    logic [COL*W_OUT-1:0] res_p1_q, res_p1_d;
    logic [1:0]           mode_p1_q, mode_p1_d;
    logic                 vld_p2_q, vld_p2_d;
    logic [COL*W_OUT-1:0] res_p2_q, res_p2_d;
    logic [1:0]           mode_p2_q, mode_p2_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;

    logic ld_p1, ld_p2, in_xfer;

    // ---- stage 0: combinational lane activation on the incoming beat ----
    always_comb begin
        res_p0      = '0;
        clip_any_p0 = 1'b0;
        lane_r      = '0;
        for (int k = 0; k < COL; k++) begin
            lane_r = lane_act($signed(bus.i_data[k*W_IN +: W_IN]), bus.i_mode, bus.i_clip);
            res_p0[k*W_OUT +: W_OUT] = lane_r[W_OUT-1:0];
            clip_any_p0 = clip_any_p0 | lane_r[W_OUT];
        end
    end

    // A stage loads when it is empty or its content leaves this cycle.
    assign ld_p2   = !vld_p2_q || bus.o_ready;
    assign ld_p1   = !vld_p1_q || ld_p2;
    assign in_xfer = bus.i_valid && ld_p1;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        res_p1_d  = res_p1_q;
        mode_p1_d = mode_p1_q;
        vld_p2_d  = vld_p2_q;
        res_p2_d  = res_p2_q;
        mode_p2_d = mode_p2_q;
        cnt_d     = cnt_q;

        // ---- stage 1: registered lane results ----
        if (ld_p1) begin
            vld_p1_d = in_xfer;
            if (in_xfer) begin
                res_p1_d  = res_p0;
                mode_p1_d = bus.i_mode;
            end
        end

        // ---- stage 2: output register ----
        if (ld_p2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                res_p2_d  = res_p1_q;
                mode_p2_d = mode_p1_q;
            end
        end

        if (i_cnt_clr)
            cnt_d = '0;
        else if (in_xfer && clip_any_p0 && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + W_CNT'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            res_p1_q  <= '0;
            mode_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            res_p2_q  <= '0;
            mode_p2_q <= '0;
            cnt_q     <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            res_p1_q  <= res_p1_d;
            mode_p1_q <= mode_p1_d;
            vld_p2_q  <= vld_p2_d;
            res_p2_q  <= res_p2_d;
            mode_p2_q <= mode_p2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.i_ready = ld_p1;
    assign bus.o_valid = vld_p2_q;
    assign bus.o_data  = res_p2_q;
    assign bus.o_mode  = mode_p2_q;
    assign o_clip_cnt  = cnt_q;

endmodule

// File: doc/relu_clip_array.md
Name: relu_clip_array

Overview:
Multi-lane, parametrised activation stage for the CNN datapath. It applies one of three run-time selectable activations to COL parallel accumulator outputs: plain ReLU with saturation, ReLU with a programmable clip threshold, or leaky ReLU. It uses a 2-stage valid/ready pipeline with back-pressure and keeps a saturating clip-event counter. It sits between the systolic-array column accumulators and the output/pooling buffer.

Parameters:
COL, 3, number of parallel lanes
W_IN, 32, per-lane input width, two's complement
W_OUT, 8, per-lane output width
LEAK_SH, 3, arithmetic right-shift applied to negative inputs in leaky mode
W_CNT, 16, clip-event counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
i_data  input  COL*W_IN  lane k at bits [k*W_IN +: W_IN], signed
i_valid  input  1  input beat valid
i_ready  output  1  block can accept a beat this cycle
i_mode  input  2  0=ReLU-sat, 1=ReLU-clip, 2=leaky, 3=treated as 0
i_clip  input  W_OUT  unsigned clip threshold, used in mode 1
o_data  output  COL*W_OUT  lane k at bits [k*W_OUT +: W_OUT]
o_valid  output  1  output beat valid
o_ready  input  1  downstream accepts
o_mode  output  2  mode that produced the current o_data
i_cnt_clr  input  1  synchronous clear of o_clip_cnt
o_clip_cnt  output  W_CNT  number of accepted beats in which at least one lane clipped

Behaviour:
- Reset (async assert, sync use): both stage-valid flags=0; o_valid=0; o_data=0; o_mode=0; o_clip_cnt=0. i_ready=1 once reset is released.
- Handshake:
  - An input transfer occurs when i_valid && i_ready. An output transfer occurs when o_valid && o_ready.
  - i_mode and i_clip are sampled with the beat and travel with it. Config changes between beats are legal.
- Pipeline:
  - S1 registers the per-lane result and a clip flag. S2 is the output register.
  - Each stage loads when it is empty or its contents move on in the same cycle.
  - i_ready = !s1_valid || !s2_valid || o_ready. This is combinational, and there are no bubbles at full rate.
  - Latency is 2 cycles from input transfer to o_valid with o_ready held high. Throughput is 1 beat/cycle.
- Output hold: while o_valid && !o_ready, o_data and o_mode stay stable. Up to 2 beats are held internally, with no loss and no duplication.
- Lane arithmetic (x = signed lane input; U = 2^W_OUT-1; SMAX = 2^(W_OUT-1)-1; SMIN = -2^(W_OUT-1)):
  - mode 0/3:
    - x<=0 → 0.
    - 0<x<=U → x.
    - x>U → U, clip flag set.
  - mode 1:
    - x<=0 → 0.
    - x>i_clip → i_clip, clip flag set.
    - Otherwise x.
    - i_clip=0 forces every lane to 0, and positive lanes flag a clip.
  - mode 2, output is signed W_OUT:
    - x>=0 → min(x, SMAX).
    - x<0 → y = x>>>LEAK_SH (floor), then max(y, SMIN).
    - The clip flag is set on either bound.
    - Example: x=-1 → -1 (0xFF). x=-8 → -1. x=-9 → -2.
- Clip counter:
  - Increments by 1 at the input transfer of any beat where the OR of the lane clip flags is 1.
  - Holds at 2^W_CNT-1; it does not wrap.
  - i_cnt_clr=1 sets the counter to 0 next cycle. Clear wins over a simultaneous increment.
- Reset mid-stream: in-flight beats are discarded, o_valid drops immediately, and the counter is cleared.
- Comparisons use the full W_IN signed value; no truncation happens before the compare.

Test Plan:
1. Mode 0, W_OUT=8, lanes {-5, 100, 3000}, o_ready=1 → o_data lanes {0, 100, 255} exactly 2 cycles after the input transfer; o_clip_cnt=1.
2. Mode 1, i_clip=6, lanes {6, 7, 0}, then i_clip=0 with {1, 0, -1} → {6, 6, 0} then {0, 0, 0}; o_clip_cnt goes 1 then 2.
3. Mode 2, LEAK_SH=3, lanes {-1, -9, -2000} then {200, 127, 0} → {0xFF, 0xFE, 0x80} then {0x7F, 0x7F, 0x00}. o_mode=2 on both beats.
4. Back-pressure: stream 10 beats with i_valid=1 and values 1..10 on all lanes, with o_ready low for cycles 3-6.
   - i_ready falls after 2 beats are held.
   - The output sequence is exactly 1..10 with no gaps or duplicates.
   - o_data stays stable while stalled.
5. Counter: preload a near-full count (W_CNT=4 build, 16 clipping beats) → holds at 15. Assert i_cnt_clr on the same cycle as a clipping transfer → reads 0.
6. Assert rst while 2 beats are in flight → o_valid=0 and o_clip_cnt=0 immediately; i_ready=1 after release; a subsequent beat appears after 2 cycles.
